// File: rtl/div_unit.sv
// div_unit -- iterative restoring radix-2 divider for DIV/DIVU in execute.
//
// Produces {HI = remainder, LO = quotient}. One quotient bit per cycle, so
// a normal divide takes DATA_W cycles in RUN plus one DONE cycle in which
// ready_o pulses. While the divide is busy, stall_o holds the pipeline.
// A flush (annul_i) abandons the operation with no ready_o pulse.
//
// Optional feature: define DIV_ZERO_FAST_EN to short-cut divide-by-zero
// through a one-cycle ZERO state (ready_o in cycle 2 instead of DATA_W+1).
//
// Ports:
//   clk        pipeline clock, rising edge
//   rst        asynchronous reset, active low
//   start_i    execute-stage instruction is a valid DIV/DIVU
//   signed_i   1 = DIV (two's complement), 0 = DIVU
//   annul_i    execute-stage flush; cancels a request or running divide
//   opdata1_i  dividend (rs)
//   opdata2_i  divisor (rt)
//   result_o   {remainder, quotient}, held until the next completion
//   ready_o    one-cycle pulse, result_o valid -> write HI/LO
//   stall_o    combinational stall request to the hazard logic
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic                  annul_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stall_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
`ifdef DIV_ZERO_FAST_EN
    , S_ZERO = 2'd3
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     dvd_q, dvd_d;     // dividend magnitude; quotient shifts in at LSB
  logic [DATA_W-1:0]     dvs_q, dvs_d;     // divisor magnitude
  logic [DATA_W-1:0]     rem_q, rem_d;     // partial remainder
  logic [DATA_W-1:0]     raw_q, raw_d;     // dividend as latched, for divide-by-zero
  logic                  negq_q, negq_d;
  logic                  negr_q, negr_d;
  logic                  dz_q, dz_d;
  logic [2*DATA_W-1:0]   result_q, result_d;

  // ---------------------------------------------------------------------
  // Operand conditioning at accept time
  // ---------------------------------------------------------------------
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic              accept;

  always_comb begin
    a_neg  = signed_i & opdata1_i[DATA_W-1];
    b_neg  = signed_i & opdata2_i[DATA_W-1];
    // Negating the most negative value wraps back to itself, which read as
    // unsigned is exactly its magnitude.
    a_mag  = a_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    b_mag  = b_neg ? (~opdata2_i + 1'b1) : opdata2_i;
    accept = (state_q == S_IDLE) & start_i & ~annul_i;
  end

  // ---------------------------------------------------------------------
  // One restoring step
  // ---------------------------------------------------------------------
  logic [DATA_W:0]   rem_sh, rem_sub;
  logic              ge;
  logic [DATA_W-1:0] rem_nx, quo_nx;
  logic              last_step;

  always_comb begin
    rem_sh    = {rem_q, dvd_q[DATA_W-1]};
    rem_sub   = rem_sh - {1'b0, dvs_q};
    ge        = (rem_sh >= {1'b0, dvs_q});
    rem_nx    = ge ? rem_sub[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    quo_nx    = {dvd_q[DATA_W-2:0], ge};
    last_step = (cnt_q == CNT_W'(DATA_W - 1));
  end

  // Final sign correction; divide-by-zero bypasses it and returns the raw
  // dividend with an all-ones quotient regardless of sign mode.
  function automatic logic [2*DATA_W-1:0] finish(
    input logic [DATA_W-1:0] rem,
    input logic [DATA_W-1:0] quo,
    input logic              dz,
    input logic              negq,
    input logic              negr,
    input logic [DATA_W-1:0] raw
  );
    logic [DATA_W-1:0] r, q;
    r = negr ? (~rem + 1'b1) : rem;
    q = negq ? (~quo + 1'b1) : quo;
    if (dz) finish = {raw, {DATA_W{1'b1}}};
    else    finish = {r, q};
  endfunction

  // ---------------------------------------------------------------------
  // State register and datapath flops
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      raw_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      raw_q    <= raw_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      dz_q     <= dz_d;
      result_q <= result_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef DIV_ZERO_FAST_EN
          state_d = (opdata2_i == '0) ? S_ZERO : S_RUN;
`else
          state_d = S_RUN;
`endif
        end
      end
      S_RUN: begin
        if (annul_i)        state_d = S_IDLE;
        else if (last_step) state_d = S_DONE;
      end
`ifdef DIV_ZERO_FAST_EN
      S_ZERO:  state_d = annul_i ? S_IDLE : S_DONE;
`endif
      // The start_i still visible in DONE belongs to the instruction that is
      // leaving execute with this result, so it is not re-accepted.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------
  always_comb begin
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    raw_d    = raw_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    dz_d     = dz_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d  = '0;
          dvd_d  = a_mag;
          dvs_d  = b_mag;
          rem_d  = '0;
          raw_d  = opdata1_i;
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
          dz_d   = (opdata2_i == '0);
        end
      end
      S_RUN: begin
        if (!annul_i) begin
          dvd_d = quo_nx;
          rem_d = rem_nx;
          cnt_d = cnt_q + CNT_W'(1);
          // Result is registered on the edge that enters DONE.
          if (last_step)
            result_d = finish(rem_nx, quo_nx, dz_q, negq_q, negr_q, raw_q);
        end
      end
`ifdef DIV_ZERO_FAST_EN
      S_ZERO: begin
        if (!annul_i)
          result_d = {raw_q, {DATA_W{1'b1}}};
      end
`endif
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    result_o = result_q;
    ready_o  = (state_q == S_DONE);
    // Gated by rst so the request from an accepting cycle cannot leak out
    // while reset is held.
    stall_o  = rst & (accept | (state_q == S_RUN)
`ifdef DIV_ZERO_FAST_EN
                              | (state_q == S_ZERO)
`endif
                             );
  end

endmodule
